// File: rtl/writeback_stage_pkg.sv
// ----------------------------------------------------------------------------
// defs -- shared processor definitions used by the writeback stage.
//   BIN_DIG  : data/address width
//   REG_NUM  : number of general registers
//   RESET_PC : architectural PC after reset
//   wb_state_t : writeback FSM states (idle / instruction pending)
//   wb_entry_t : one executed instruction held between accept and commit
// ----------------------------------------------------------------------------
package defs;

  localparam int BIN_DIG = 32;
  localparam int REG_NUM = 32;
  localparam logic [BIN_DIG-1:0] RESET_PC = '0;

  typedef enum logic {
    WB_IDLE = 1'b0,
    WB_PEND = 1'b1
  } wb_state_t;

  typedef struct packed {
    logic [BIN_DIG-1:0] pc;
    logic [BIN_DIG-1:0] next_pc;
    logic [4:0]         rd;
    logic               rd_we;
    logic [BIN_DIG-1:0] rd_value;
  } wb_entry_t;

endpackage

// File: rtl/writeback_stage_if.sv
// ----------------------------------------------------------------------------
// writeback_stage_if -- execute-to-writeback handshake bundle.
//   ex_valid/ex_ready : valid/ready handshake (transfer when both high)
//   ex_pc, ex_next_pc : PC of the instruction and the next PC exec computed
//   ex_rd, ex_rd_we   : destination register and its write enable
//   ex_rd_value       : value to write to rd
// master = exec stage (producer), slave = writeback stage (consumer).
// ----------------------------------------------------------------------------
interface writeback_stage_if #(
  parameter int BIN_DIG = defs::BIN_DIG
);

  logic               ex_valid;
  logic               ex_ready;
  logic [BIN_DIG-1:0] ex_pc;
  logic [BIN_DIG-1:0] ex_next_pc;
  logic [4:0]         ex_rd;
  logic               ex_rd_we;
  logic [BIN_DIG-1:0] ex_rd_value;

  modport master (
    output ex_valid, ex_pc, ex_next_pc, ex_rd, ex_rd_we, ex_rd_value,
    input  ex_ready
  );

  modport slave (
    input  ex_valid, ex_pc, ex_next_pc, ex_rd, ex_rd_we, ex_rd_value,
    output ex_ready
  );

endinterface

// File: rtl/writeback_stage_gen_regfile.sv
// ----------------------------------------------------------------------------
// gen_regfile -- general register file with one write port and the whole
// array exposed as an output (decode/exec read it directly).
//   clk, rst_n : clock, asynchronous active-low reset (clears every register)
//   we         : write enable
//   waddr      : register index to write
//   wdata      : write data
//   regs       : full register array; entry 0 is hard-wired to zero
// ----------------------------------------------------------------------------
module gen_regfile
  import defs::*;
#(
  parameter int BIN_DIG = defs::BIN_DIG,
  parameter int REG_NUM = defs::REG_NUM
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            we,
  input  logic [4:0]                      waddr,
  input  logic [BIN_DIG-1:0]              wdata,
  output logic [REG_NUM-1:0][BIN_DIG-1:0] regs
);

  for (genvar gi = 0; gi < REG_NUM; gi++) begin : g_reg
    if (gi == 0) begin : g_zero
      // x0 has no storage, so writes to it simply vanish.
      assign regs[gi] = '0;
    end else begin : g_store
      logic [BIN_DIG-1:0] reg_q;
      logic [BIN_DIG-1:0] reg_d;

      always_comb begin
        reg_d = reg_q;
        if (we && (waddr == 5'(gi))) begin
          reg_d = wdata;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign regs[gi] = reg_q;
    end
  end

endmodule

// File: rtl/writeback_stage.sv
// ----------------------------------------------------------------------------
// writeback_stage -- final pipeline stage. Accepts one executed instruction
// per cycle, holds it for one cycle, then commits it: register file write,
// architectural PC update and retire count. A committed next_pc that is not
// pc+4 raises flush during the cycle before the committing edge.
//   clk, rst_n       : clock, asynchronous active-low reset
//   ex_if (slave)    : execute-to-writeback handshake
//   halt             : debug hold, freezes both commit and acceptance
//   curr_pc_reg      : architectural PC
//   curr_general_reg : register file contents (x0 reads 0)
//   flush            : front-end redirect to curr_pc_reg
//   retire_count     : committed instruction count (wraps)
// ----------------------------------------------------------------------------
module writeback_stage
  import defs::*;
#(
  parameter int                   BIN_DIG  = defs::BIN_DIG,
  parameter int                   REG_NUM  = defs::REG_NUM,
  parameter logic [BIN_DIG-1:0]   RESET_PC = defs::RESET_PC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  writeback_stage_if.slave                ex_if,
  input  logic                            halt,
  output logic [BIN_DIG-1:0]              curr_pc_reg,
  output logic [REG_NUM-1:0][BIN_DIG-1:0] curr_general_reg,
  output logic                            flush,
  output logic [31:0]                     retire_count
);

  wb_state_t          state_q, state_d;
  wb_entry_t          wb_q, wb_d;
  logic [BIN_DIG-1:0] pc_q, pc_d;
  logic [31:0]        retire_q, retire_d;

  logic pend;
  logic redirect;
  logic accept;
  logic commit;

  assign pend = (state_q == WB_PEND);

  // Sum is kept at BIN_DIG bits so pc = all-ones-minus-3 with next_pc = 0
  // counts as sequential.
  always_comb begin
    logic [BIN_DIG-1:0] seq_pc;
    seq_pc   = wb_q.pc + BIN_DIG'(4);
    redirect = pend && (wb_q.next_pc != seq_pc);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      WB_IDLE: if (accept) state_d = WB_PEND;
      WB_PEND: if (commit) state_d = accept ? WB_PEND : WB_IDLE;
      default: state_d = WB_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // During a redirect the stage refuses new work, so the instruction exec
  // presents alongside the flush is dropped rather than committed on the
  // wrong path.
  always_comb begin
    ex_if.ex_ready = !halt && !redirect;
    flush          = redirect && !halt;
    accept         = ex_if.ex_valid && ex_if.ex_ready;
    commit         = pend && !halt;
  end

  // ---------------- holding register / architectural state ----------------
  always_comb begin
    wb_d     = wb_q;
    pc_d     = pc_q;
    retire_d = retire_q;
    if (accept) begin
      wb_d.pc       = ex_if.ex_pc;
      wb_d.next_pc  = ex_if.ex_next_pc;
      wb_d.rd       = ex_if.ex_rd;
      wb_d.rd_we    = ex_if.ex_rd_we;
      wb_d.rd_value = ex_if.ex_rd_value;
    end
    if (commit) begin
      pc_d     = wb_q.next_pc;
      retire_d = retire_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_q     <= '0;
      pc_q     <= RESET_PC;
      retire_q <= '0;
    end else begin
      wb_q     <= wb_d;
      pc_q     <= pc_d;
      retire_q <= retire_d;
    end
  end

  gen_regfile #(
    .BIN_DIG (BIN_DIG),
    .REG_NUM (REG_NUM)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (commit && wb_q.rd_we),
    .waddr (wb_q.rd),
    .wdata (wb_q.rd_value),
    .regs  (curr_general_reg)
  );

  assign curr_pc_reg  = pc_q;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_writeback_stage.sv
// ----------------------------------------------------------------------------
// tb_writeback_stage -- directed scenarios followed by random traffic, all
// checked against an instruction-level reference model: a queue of accepted
// but uncommitted instructions, a register array, a PC and a retire counter.
// ----------------------------------------------------------------------------
module tb_writeback_stage;
  import defs::*;

  logic                clk;
  logic                rst_n;
  logic                halt;
  logic [31:0]         curr_pc_reg;
  logic [31:0][31:0]   curr_general_reg;
  logic                flush;
  logic [31:0]         retire_count;

  int checks = 0;
  int errors = 0;

  // Reference model
  wb_entry_t         pend_q[$];
  logic [31:0]       m_regs[32];
  logic [31:0]       m_pc;
  logic [31:0]       m_cnt;

  writeback_stage_if #(.BIN_DIG(32)) ex_if ();

  writeback_stage #(
    .BIN_DIG  (32),
    .REG_NUM  (32),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .ex_if            (ex_if),
    .halt             (halt),
    .curr_pc_reg      (curr_pc_reg),
    .curr_general_reg (curr_general_reg),
    .flush            (flush),
    .retire_count     (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pend_q.delete();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pc  = 32'h0000_0000;
    m_cnt = '0;
  endtask

  task automatic check_arch(input string where);
    chk({where, " curr_pc_reg"}, curr_pc_reg, m_pc);
    chk({where, " retire_count"}, retire_count, m_cnt);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("%s x%0d", where, i), curr_general_reg[i], m_regs[i]);
    end
  endtask

  // One clock cycle: drive at the falling edge, check the combinational
  // handshake outputs, advance the model at the rising edge, then check the
  // architectural state just after it.
  task automatic cycle(input bit v, input logic [31:0] p, input logic [31:0] np,
                       input logic [4:0] r, input bit we, input logic [31:0] val,
                       input bit h, input string tag);
    bit        redir;
    bit        exp_ready;
    bit        exp_flush;
    wb_entry_t e;
    ex_if.ex_valid    = v;
    ex_if.ex_pc       = p;
    ex_if.ex_next_pc  = np;
    ex_if.ex_rd       = r;
    ex_if.ex_rd_we    = we;
    ex_if.ex_rd_value = val;
    halt              = h;
    #1;
    redir     = (pend_q.size() != 0) && (pend_q[0].next_pc != pend_q[0].pc + 32'd4);
    exp_ready = !h && !redir;
    exp_flush = redir && !h;
    chk({tag, " ex_ready"}, {31'b0, ex_if.ex_ready}, {31'b0, exp_ready});
    chk({tag, " flush"},    {31'b0, flush},          {31'b0, exp_flush});
    @(posedge clk);
    if (pend_q.size() != 0 && !h) begin
      e = pend_q.pop_front();
      if (e.rd_we && e.rd != 5'd0) m_regs[e.rd] = e.rd_value;
      m_pc  = e.next_pc;
      m_cnt = m_cnt + 32'd1;
    end
    if (v && exp_ready) begin
      pend_q.push_back('{pc: p, next_pc: np, rd: r, rd_we: we, rd_value: val});
    end
    #1;
    check_arch(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag);
    cycle(1'b0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  initial begin
    logic [31:0] rp;
    logic [31:0] np;
    logic [31:0] cnt_before;

    rst_n             = 1'b0;
    halt              = 1'b0;
    ex_if.ex_valid    = 1'b0;
    ex_if.ex_pc       = '0;
    ex_if.ex_next_pc  = '0;
    ex_if.ex_rd       = '0;
    ex_if.ex_rd_we    = 1'b0;
    ex_if.ex_rd_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_arch("reset");
    chk("reset ex_ready", {31'b0, ex_if.ex_ready}, 32'd1);
    chk("reset flush",    {31'b0, flush},          32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single write
    cycle(1'b1, 32'h100, 32'h104, 5'd5, 1'b1, 32'h1234, 1'b0, "single_acc");
    idle("single_commit");
    chk("single x5", curr_general_reg[5], 32'h1234);
    chk("single pc", curr_pc_reg, 32'h104);

    // x0 write is discarded, PC still advances
    cycle(1'b1, 32'h104, 32'h108, 5'd0, 1'b1, 32'hDEAD, 1'b0, "x0_acc");
    idle("x0_commit");
    chk("x0 reads zero", curr_general_reg[0], 32'h0);
    chk("x0 pc", curr_pc_reg, 32'h108);

    // Back-to-back sequential
    cnt_before = m_cnt;
    for (int k = 0; k < 4; k++) begin
      cycle(1'b1, 32'h108 + 32'(4 * k), 32'h10C + 32'(4 * k), 5'(k + 1), 1'b1,
            32'hA000 + 32'(k), 1'b0, $sformatf("b2b_%0d", k));
    end
    idle("b2b_drain");
    chk("b2b retired", retire_count - cnt_before, 32'd4);

    // Redirect: the instruction offered during flush is dropped
    cycle(1'b1, 32'h200, 32'h240, 5'd0, 1'b0, 32'h0, 1'b0, "redir_acc");
    cycle(1'b1, 32'h240, 32'h244, 5'd7, 1'b1, 32'h55, 1'b0, "redir_flush");
    chk("redir pc", curr_pc_reg, 32'h240);
    cnt_before = m_cnt;
    idle("redir_after");
    chk("redir idle no commit", retire_count, cnt_before);

    // PC wrap is sequential
    cycle(1'b1, 32'hFFFF_FFFC, 32'h0, 5'd3, 1'b1, 32'hABC, 1'b0, "wrap_acc");
    idle("wrap_commit");

    // Halt holds the pending instruction
    cycle(1'b1, 32'h300, 32'h304, 5'd9, 1'b1, 32'h999, 1'b0, "halt_acc");
    cnt_before = m_cnt;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 32'h304, 32'h308, 5'd11, 1'b1, 32'h1, 1'b1, $sformatf("halt_%0d", k));
    end
    chk("halt retire held", retire_count, cnt_before);
    idle("halt_release");
    chk("halt x9", curr_general_reg[9], 32'h999);

    // Reset while an instruction is pending
    cycle(1'b1, 32'h400, 32'h404, 5'd10, 1'b1, 32'h777, 1'b0, "rst_acc");
    rst_n = 1'b0;
    #1;
    model_reset();
    check_arch("rst_async");
    chk("rst_async flush", {31'b0, flush}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    idle("rst_after");
    chk("rst x10 never written", curr_general_reg[10], 32'h0);

    // Random traffic
    rp = 32'h1000;
    for (int n = 0; n < 400; n++) begin
      np = ($urandom_range(0, 4) == 0) ? ($urandom() & 32'hFFFF_FFFC) : rp + 32'd4;
      cycle($urandom_range(0, 9) < 7, rp, np, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom(), $urandom_range(0, 9) < 2,
            $sformatf("rnd_%0d", n));
      rp = np;
    end
    idle("rnd_drain");
    idle("rnd_drain2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage.md
# writeback_stage

Final pipeline stage of the processor: the consumer of the execute-to-writeback interface. It accepts one executed instruction per cycle over a valid/ready handshake and registers it for one cycle. It then commits the instruction: it writes the general register file, updates the architectural PC and counts the retired instruction. It drives `curr_general_reg` and `curr_pc_reg` back to decode/exec, and raises `flush` when the committed next-PC breaks sequential flow.

## Interface
Parameters:
- `BIN_DIG`, default 32: data and address width.
- `REG_NUM`, default 32: number of general registers.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `ex_valid`  in  1  the exec stage presents an instruction.
- `ex_ready`  out  1  the stage can accept an instruction this cycle.
- `ex_pc`  in  BIN_DIG  PC of the presented instruction.
- `ex_next_pc`  in  BIN_DIG  next PC computed by exec.
- `ex_rd`  in  5  destination register index.
- `ex_rd_we`  in  1  the instruction writes `rd` (low for branches and stores).
- `ex_rd_value`  in  BIN_DIG  value to write to `rd`.
- `halt`  in  1  debug hold: freezes commit and acceptance.
- `curr_pc_reg`  out  BIN_DIG  architectural PC.
- `curr_general_reg`  out  REG_NUM x BIN_DIG  register file contents.
- `flush`  out  1  redirect: the front end discards in-flight work and refetches from `curr_pc_reg`.
- `retire_count`  out  32  count of committed instructions.

## Operation
- There are 2 states, IDLE and PEND, plus a holding register `wb_q`. `wb_q` holds the pc, next_pc, rd, rd_we and rd_value of the captured instruction.
- Accept condition: `ex_valid && ex_ready` at a clock edge. On accept, the presented instruction is loaded into `wb_q` and the state becomes PEND.
- Commit condition: state is PEND and `halt` is 0 at a clock edge. On commit, all of the following happen at that edge:
  - If `rd_we` is 1 and `rd` is not 0, `curr_general_reg[rd]` is set to `rd_value`.
  - `curr_pc_reg` is set to `next_pc`.
  - `retire_count` increments by 1.
- `x0` always reads 0; writes to `x0` are discarded.
- Redirect condition: state is PEND and `wb_q.next_pc != wb_q.pc + 4`, with the sum taken modulo 2^BIN_DIG.
- `ex_ready` = `!halt && !(state==PEND && redirect)`.
- `flush` = `state==PEND && redirect && !halt`. It is combinational, so it is high during the cycle that precedes the committing edge.
- Any `ex_valid` presented while `flush` is high is not accepted; the front end drops it.
- Transitions:
  - IDLE → PEND on accept.
  - PEND → PEND on commit with a simultaneous accept (back-to-back).
  - PEND → IDLE on commit without accept. This includes every redirect commit.
  - PEND stays PEND while `halt` is 1.
- `retire_count` wraps from 32'hFFFF_FFFF to 0.
- The `+4` comparison wraps, so `pc = 32'hFFFF_FFFC` with `next_pc = 0` is sequential.

## Timing
- Reset values while `rst_n` is 0:
  - state = IDLE; `wb_q` cleared.
  - `curr_pc_reg = RESET_PC`; all `curr_general_reg` = 0.
  - `retire_count = 0`; `flush = 0`.
  - `ex_ready = 1` (subject to `halt`).
- Latency: an instruction accepted at edge k becomes architecturally visible at edge k+1 if `halt` is 0 during the cycle between those edges.
- Throughput: 1 instruction per cycle for sequential flow. A redirect costs 1 cycle with `ex_ready` low.
- `halt` asserted with state PEND: `wb_q` is held, nothing commits and `ex_ready` is 0. Commit resumes at the first edge with `halt` = 0.
- Reset asserted mid-operation: the pending instruction is discarded and never commits. All outputs return to their reset values immediately (asynchronously).

## Structure
- Additions to the shared package `defs`:
  - `wb_entry_t` packed struct (pc, next_pc, rd, rd_we, rd_value).
  - `wb_state_t` enum {WB_IDLE, WB_PEND}.
  - `REG_NUM` and `RESET_PC` constants, reusing the existing `BIN_DIG`.
- Sub-module `gen_regfile`:
  - Inputs: write enable, write address and write data; asynchronous reset clears it.
  - Output: the whole register array, with `x0` forced to 0.
  - The stage instantiates it once.

## Test plan
- Reset: release `rst_n` → `curr_pc_reg = RESET_PC`, all registers 0, `retire_count = 0`, `ex_ready = 1`, `flush = 0`.
- Single write: accept pc=0x100, next_pc=0x104, rd=5, rd_we=1, value=0x1234 → one edge later `x5 = 0x1234`, `curr_pc_reg = 0x104`, `retire_count = 1`, `flush` never high.
- `x0` write: commit rd=0, rd_we=1, value=0xDEAD → `x0` still reads 0 and the PC advances.
- Back-to-back: 4 sequential instructions on consecutive cycles with `ex_valid` held high → `ex_ready` stays 1, one commit per edge, `retire_count = 4`.
- Redirect: accept pc=0x200, next_pc=0x240, rd_we=0 while `ex_valid` stays high →
  - the following cycle has `flush = 1` and `ex_ready = 0`, and the concurrent `ex_valid` is dropped;
  - then `curr_pc_reg = 0x240` and state is IDLE.
- Halt and reset mid-flight:
  - Assert `halt` for 3 cycles with PEND → no commit and `retire_count` unchanged; the commit lands on the first edge after `halt` drops.
  - Pulse `rst_n` low while PEND → the pending write never appears.
